vga_timing_ctrl: RTL and testbench
==================================

Name: vga_timing_ctrl

Overview:
Sequencer for the VGA output path. It consumes the one-cycle pixel-clock tick made from clk_in by the clock divider and generates the horizontal and vertical counters, hsync/vsync, the active-video window and frame/line markers for the pixel generator. A run/stop handshake ensures frames only start and stop on frame boundaries, so the monitor never sees a truncated frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixel ticks)
H_SYNC, 96, hsync pulse width (pixel ticks)
H_BP, 48, horizontal back porch (pixel ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
CW, 10, counter width; must satisfy 2^CW >= H total and >= V total

Ports:
clk_in  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high; clock clk_in
pix_en  input  1  pixel tick, one clk_in cycle wide; counters advance only when high
run  input  1  level request to produce video
busy  output  1  high while a frame is in progress (RUN or DRAIN)
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
video_on  output  1  high inside the H_ACTIVE x V_ACTIVE window
pixel_x  output  CW  current horizontal count
pixel_y  output  CW  current vertical count
line_start  output  1  one-cycle pulse when pixel_x becomes 0
frame_start  output  1  one-cycle pulse when (pixel_x, pixel_y) becomes (0,0) at frame start

Behaviour:
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal regions: active [0, H_ACTIVE-1], FP, SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], BP up to H_TOT-1. Vertical regions are analogous (vsync lines [490,491]).
- Reset: state IDLE; pixel_x=0, pixel_y=0; hsync=vsync=~SYNC_POL; video_on=0; busy=0; line_start=frame_start=0.
- All outputs are registered. They change on the same clk_in edge as the counters and describe the new count. There is no extra pipeline latency.
- FSM states:
  - IDLE: counters held at 0, syncs inactive, video_on=0, busy=0. If run=1 and pix_en=1, go to RUN. On that edge pixel_x=pixel_y=0 and frame_start=line_start=1. Counting starts at the next pix_en.
  - RUN: on each pix_en, pixel_x increments. At H_TOT-1 it wraps to 0, pulses line_start, and pixel_y increments. pixel_y wraps from V_TOT-1 to 0 and pulses frame_start. If run=0 at any time, go to DRAIN, with no change to the counters.
  - DRAIN: counting continues exactly as in RUN until the wrap from (H_TOT-1, V_TOT-1). At that pix_en:
    - if run=1, return to RUN, with frame_start=1 and counters at (0,0);
    - if run=0, go to IDLE, with counters at 0, syncs inactive and busy=0, and no frame_start.
  - A run that drops and returns mid-frame (run=1 again while in DRAIN) never restarts the counters mid-frame.
- hsync = SYNC_POL in the horizontal SYNC region, else ~SYNC_POL. vsync behaves the same over the vertical SYNC region and is independent of the horizontal position.
- video_on = 1 only when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE, and the state is RUN or DRAIN.
- Counter compare and increment is performed at CW bits; no other saturation.
- pix_en=0: all state and outputs hold, except pulses, which last exactly one clk_in cycle.
- Consecutive pix_en cycles (divide-by-1) are legal.
- Reset asserted mid-frame forces the reset values immediately (asynchronously). After release, the block waits in IDLE for run.

Test Plan:
1. Reset with run=0 and pix_en toggling every 2nd cycle -> stays IDLE; hsync=vsync=1, video_on=0, pixel_x=pixel_y=0, busy=0.
2. Raise run with pix_en every 2nd clk_in -> frame_start is a 1-cycle pulse with busy=1. hsync goes low exactly at pixel_x=656 and high at 752. Line period = 800 ticks = 1600 clk_in cycles.
3. Full frame -> video_on is high for 640x480 = 307200 ticks per frame; vsync is low only for pixel_y 490..491; frame_start recurs every 420000 ticks.
4. Drop run at pixel_y=100 -> counting continues to (799,524), then IDLE with busy=0. No frame_start, and the counters stay 0.
5. Drop run at pixel_y=100 and re-raise at pixel_y=300 -> no discontinuity; the next frame starts seamlessly with a frame_start pulse at the wrap.
6. Assert reset at pixel_x=400, pixel_y=200 -> all outputs take their reset values in the same cycle. After release with run=1, the first frame_start appears on the first pix_en.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: run/pixel-tick requests in, sync/counter/marker outputs back.
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          pix_en;
    logic          run;
    logic          busy;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_en, run,
        input  busy, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input  pix_en, run,
        output busy, hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA h/v counters, syncs and markers; frames start and stop only on
// frame boundaries.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input logic         clk_in,
    input logic         reset,
    vga_timing_if.slave bus
);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic          x_last, y_last, wrap;
    logic [CW-1:0] tx, ty;
    logic          hs_n, vs_n, von_n;

    // Next position and the outputs describing it, so registered outputs match the new count.
    always_comb begin
        x_last = bus.pixel_x == H_LAST;
        y_last = bus.pixel_y == V_LAST;
        wrap   = x_last && y_last;
        tx     = (state == IDLE || x_last) ? '0 : bus.pixel_x + 1'b1;
        ty     = (state == IDLE || wrap) ? '0 : bus.pixel_y + CW'(x_last);
        hs_n   = (tx >= HS_BEG && tx <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_n   = (ty >= VS_BEG && ty <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        von_n  = tx < H_ACT && ty < V_ACT;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.hsync       <= ~SYNC_POL;
            bus.vsync       <= ~SYNC_POL;
            bus.video_on    <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
            if (state == IDLE) begin
                if (bus.run && bus.pix_en) begin
                    state           <= RUN;
                    bus.busy        <= 1'b1;
                    bus.line_start  <= 1'b1;
                    bus.frame_start <= 1'b1;
                    bus.pixel_x     <= tx;
                    bus.pixel_y     <= ty;
                    bus.hsync       <= hs_n;
                    bus.vsync       <= vs_n;
                    bus.video_on    <= von_n;
                end
            end else if (bus.pix_en && wrap && !bus.run) begin
                state        <= IDLE;
                bus.busy     <= 1'b0;
                bus.pixel_x  <= '0;
                bus.pixel_y  <= '0;
                bus.hsync    <= ~SYNC_POL;
                bus.vsync    <= ~SYNC_POL;
                bus.video_on <= 1'b0;
            end else begin
                // A run that returns mid-frame only takes effect at the frame wrap.
                state <= ((bus.pix_en && wrap) || (state == RUN && bus.run)) ? RUN : DRAIN;
                if (bus.pix_en) begin
                    bus.line_start  <= x_last;
                    bus.frame_start <= wrap;
                    bus.pixel_x     <= tx;
                    bus.pixel_y     <= ty;
                    bus.hsync       <= hs_n;
                    bus.vsync       <= vs_n;
                    bus.video_on    <= von_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed and randomized checks of vga_timing_ctrl against a
// frame-position model (one integer position per frame), using a reduced timing.
module tb_vga_timing_ctrl;
    localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VSW = 2, VBP = 1;
    localparam int CW = 5;
    localparam bit SP = 1'b0;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FT = HT * VT;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    vga_timing_if #(.CW(CW)) bus ();

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(SP), .CW(CW)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int   tests = 0, failed = 0;
    int   m_pos = 0;
    bit   m_busy = 0, m_ls = 0, m_fs = 0;
    bit   pe_t = 0;
    bit   have_fs = 0;
    int   tick_cnt = 0, von_cnt = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    task automatic check(input string tag);
        logic [6+2*CW-1:0] got, exp;
        int x, y;
        logic ehs, evs;
        x   = m_pos % HT;
        y   = m_pos / HT;
        ehs = (m_busy && x >= HA + HFP && x < HA + HFP + HSW) ? SP : ~SP;
        evs = (m_busy && y >= VA + VFP && y < VA + VFP + VSW) ? SP : ~SP;
        exp = {m_busy, ehs, evs, m_busy && x < HA && y < VA, m_ls, m_fs, CW'(x), CW'(y)};
        got = {bus.busy, bus.hsync, bus.vsync, bus.video_on, bus.line_start, bus.frame_start,
               bus.pixel_x, bus.pixel_y};
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s got=%h exp=%h (busy,hs,vs,von,ls,fs,x,y)", tag, got, exp);
        end
    endtask

    // mode 0: pix_en every 2nd cycle, 1: random, 2: every cycle
    task automatic step(input int mode, input logic r, input string tag);
        logic pe;
        pe_t = ~pe_t;
        pe = (mode == 0) ? pe_t : (mode == 1) ? ($urandom_range(2) != 0) : 1'b1;
        bus.pix_en = pe;
        bus.run    = r;
        @(posedge clk_in);
        m_ls = 0;
        m_fs = 0;
        if (!m_busy) begin
            if (r && pe) begin
                m_busy = 1; m_pos = 0; m_ls = 1; m_fs = 1;
            end
        end else if (pe) begin
            if (m_pos == FT - 1) begin
                m_pos = 0;
                if (r) begin
                    m_ls = 1; m_fs = 1;
                end else m_busy = 0;
            end else begin
                m_pos++;
                m_ls = (m_pos % HT == 0);
            end
        end
        #1 check(tag);
        if (!m_busy) have_fs = 0;
        if (pe && bus.busy) begin
            if (bus.frame_start) begin
                if (have_fs) begin
                    tests++;
                    assert (tick_cnt == FT) else begin
                        failed++;
                        $error("FAIL frame_period got=%0d exp=%0d", tick_cnt, FT);
                    end
                    tests++;
                    assert (von_cnt == HA * VA) else begin
                        failed++;
                        $error("FAIL video_ticks got=%0d exp=%0d", von_cnt, HA * VA);
                    end
                end
                have_fs  = 1;
                tick_cnt = 0;
                von_cnt  = 0;
            end
            tick_cnt++;
            von_cnt += int'(bus.video_on);
            if (bus.hsync !== prev_hs) begin
                tests++;
                assert (int'(bus.pixel_x) == ((bus.hsync == SP) ? HA + HFP : HA + HFP + HSW)) else begin
                    failed++;
                    $error("FAIL hsync_edge hs=%b got_x=%0d", bus.hsync, bus.pixel_x);
                end
            end
            if (bus.vsync !== prev_vs) begin
                tests++;
                assert (bus.pixel_x == '0 &&
                        int'(bus.pixel_y) == ((bus.vsync == SP) ? VA + VFP : VA + VFP + VSW)) else begin
                    failed++;
                    $error("FAIL vsync_edge vs=%b got_x=%0d got_y=%0d", bus.vsync, bus.pixel_x, bus.pixel_y);
                end
            end
        end
        prev_hs = bus.hsync;
        prev_vs = bus.vsync;
    endtask

    task automatic run_to(input int mode, input logic r, input int tx, input int ty, input string tag);
        for (int i = 0; i < 4 * FT && !(m_busy && m_pos == ty * HT + tx); i++) step(mode, r, tag);
        tests++;
        assert (bus.busy === 1'b1 && bus.pixel_x === CW'(tx) && bus.pixel_y === CW'(ty)) else begin
            failed++;
            $error("FAIL %s_reach got=(%0d,%0d,busy=%b) exp=(%0d,%0d,busy=1)",
                   tag, bus.pixel_x, bus.pixel_y, bus.busy, tx, ty);
        end
    endtask

    initial begin
        bus.pix_en = 1'b0;
        bus.run    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 check("reset");
        @(negedge clk_in) reset = 1'b0;

        repeat (20) step(0, 1'b0, "idle");
        repeat (3 * FT * 2 + 4) step(0, 1'b1, "run_div2");

        run_to(1, 1'b1, 0, 3, "to_y3");
        for (int i = 0; i < 4 * FT && m_busy; i++) step(1, 1'b0, "drain");
        tests++;
        assert (bus.busy === 1'b0 && bus.pixel_x === '0 && bus.pixel_y === '0) else begin
            failed++;
            $error("FAIL drain_end got=(%0d,%0d,busy=%b) exp=(0,0,busy=0)", bus.pixel_x, bus.pixel_y, bus.busy);
        end
        repeat (20) step(1, 1'b0, "idle2");

        run_to(1, 1'b1, 0, 2, "to_y2");
        run_to(1, 1'b0, 0, 4, "dropped");
        run_to(1, 1'b1, HT - 1, VT - 1, "reraised");
        step(2, 1'b1, "seam");
        tests++;
        assert (bus.frame_start === 1'b1 && bus.busy === 1'b1) else begin
            failed++;
            $error("FAIL seam_fs got=%b/%b exp=1/1", bus.frame_start, bus.busy);
        end

        repeat (3 * FT) step(2, $urandom_range(9) != 0, "rand_run");
        repeat (3 * FT) step(1, $urandom_range(19) != 0, "rand_both");

        run_to(2, 1'b1, 5, 3, "to_reset");
        #3 reset = 1'b1;
        m_busy = 0; m_pos = 0; m_ls = 0; m_fs = 0; have_fs = 0;
        #1 check("async_reset");
        @(posedge clk_in);
        @(negedge clk_in) reset = 1'b0;
        step(2, 1'b1, "restart");
        tests++;
        assert (bus.frame_start === 1'b1 && bus.line_start === 1'b1) else begin
            failed++;
            $error("FAIL restart_fs got=%b/%b exp=1/1", bus.frame_start, bus.line_start);
        end
        repeat (FT + 10) step(2, 1'b1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
